shift_pipe: RTL

- Two-stage pipelined 32-bit shifter with valid/ready handshakes on input and output.
- Left shifts are built on the right-shift core: the operand is bit-reversed before the shift and the result is reversed back afterwards.
- Sits between operand select and writeback of the ALU datapath.
- Replaces the single-cycle combinational barrel shifter where timing requires a register split.

---
 rtl/shift_pipe.sv | 117 +++++++++++
 1 files changed

// File: rtl/shift_pipe.sv
// Two-stage pipelined 32-bit shifter (SRL/SRA/SLL) with valid/ready on both sides.
// Define SHIFT_PIPE_ROTATE_EN to make op 11 a rotate-right; otherwise op 11 decodes as SRL.
module shift_pipe #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic [SHAMT_W-1:0] in_shamt,
   input  logic [1:0]         in_op,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_data
);

   typedef enum logic [1:0] {
      OP_SRL = 2'b00,
      OP_SRA = 2'b01,
      OP_SLL = 2'b10,
      OP_ROR = 2'b11
   } shift_op_e;

   logic               s1_valid;
   logic               s1_left;
   logic               s1_fill;
   logic [WIDTH-1:0]   s1_operand;
   logic [SHAMT_W-1:0] s1_shamt;
`ifdef SHIFT_PIPE_ROTATE_EN
   logic               s1_rot;
`endif
   logic               s2_valid;
   logic               s2_adv;
   logic               s1_adv;
   logic               in_fire;
   logic [WIDTH-1:0]   shifted;
   logic [WIDTH-1:0]   prev;
   logic [WIDTH-1:0]   result;
   logic [SHAMT_W-1:0] src;
   shift_op_e          op;

   function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) r[i] = x[WIDTH-1-i];
      return r;
   endfunction

   assign op        = shift_op_e'(in_op);
   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign in_fire   = in_valid && s1_adv;
   assign out_valid = s2_valid;

   // Log shifter, 16/8/4/2/1; src wraps modulo WIDTH so the rotate path reuses the same index.
   always_comb begin
      shifted = s1_operand;
      prev    = s1_operand;
      src     = '0;
      for (int s = SHAMT_W - 1; s >= 0; s--) begin
         if (s1_shamt[s]) begin
            prev = shifted;
            for (int i = 0; i < WIDTH; i++) begin
               src = SHAMT_W'(i + (1 << s));
               if (i + (1 << s) < WIDTH)
                  shifted[i] = prev[src];
`ifdef SHIFT_PIPE_ROTATE_EN
               else if (s1_rot)
                  shifted[i] = prev[src];
`endif
               else
                  shifted[i] = s1_fill;
            end
         end
      end
      result = s1_left ? bit_rev(shifted) : shifted;
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid   <= 1'b0;
         s1_left    <= 1'b0;
         s1_fill    <= 1'b0;
         s1_operand <= '0;
         s1_shamt   <= '0;
`ifdef SHIFT_PIPE_ROTATE_EN
         s1_rot     <= 1'b0;
`endif
      end else begin
         if (s1_adv) s1_valid <= in_valid;
         if (in_fire) begin
            s1_left    <= (op == OP_SLL);
            s1_operand <= (op == OP_SLL) ? bit_rev(in_data) : in_data;
            s1_fill    <= (op == OP_SRA) && in_data[WIDTH-1];
            s1_shamt   <= in_shamt;
`ifdef SHIFT_PIPE_ROTATE_EN
            s1_rot     <= (op == OP_ROR);
`endif
         end
      end
   end

   // out_data only moves when stage 2 advances, so it holds under backpressure and after drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         out_data <= '0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) out_data <= result;
      end
   end

endmodule
